// File: rtl/aq_gemac_udp_send_arb.sv
`default_nettype none
// ============================================================================
// Module   : aq_gemac_udp_send_arb
// Purpose  : Round-robin arbiter that lets NUM_CH UDP clients share the single
//            SEND_* port of aq_gemac_udp_ctrl. A grant covers one whole
//            datagram. The header is captured at grant time. Zero-length
//            requests are rejected. A watchdog abandons a request if the
//            downstream never raises SEND_BUSY.
// Ports    : CLK/RST_N       clock, asynchronous active-low reset
//            CH_SEND_*       per-channel client side (packed, ch i at [W*i +: W])
//            SEND_*          single downstream send port (header + payload)
//            ACTIVE_CH       index of the granted channel
//            ERR_LENGTH      1-cycle pulse, zero-length request rejected
//            ERR_TIMEOUT     1-cycle pulse, SEND_BUSY never rose
// Revision : 1.0  initial release
// ============================================================================
module aq_gemac_udp_send_arb #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NUM_CH-1:0]    CH_SEND_REQUEST,
    input  logic [16*NUM_CH-1:0] CH_SEND_LENGTH,
    input  logic [48*NUM_CH-1:0] CH_SEND_MAC_ADDRESS,
    input  logic [32*NUM_CH-1:0] CH_SEND_IP_ADDRESS,
    input  logic [16*NUM_CH-1:0] CH_SEND_DST_PORT,
    input  logic [16*NUM_CH-1:0] CH_SEND_SRC_PORT,
    input  logic [NUM_CH-1:0]    CH_SEND_DATA_VALID,
    input  logic [32*NUM_CH-1:0] CH_SEND_DATA,
    output logic [NUM_CH-1:0]    CH_SEND_DATA_READ,
    output logic [NUM_CH-1:0]    CH_SEND_BUSY,
    output logic [NUM_CH-1:0]    CH_SEND_DONE,
    output logic                 SEND_REQUEST,
    output logic [15:0]          SEND_LENGTH,
    output logic [47:0]          SEND_MAC_ADDRESS,
    output logic [31:0]          SEND_IP_ADDRESS,
    output logic [15:0]          SEND_DST_PORT,
    output logic [15:0]          SEND_SRC_PORT,
    input  logic                 SEND_BUSY,
    output logic                 SEND_DATA_VALID,
    input  logic                 SEND_DATA_READ,
    output logic [31:0]          SEND_DATA,
    output logic [CH_W-1:0]      ACTIVE_CH,
    output logic                 ERR_LENGTH,
    output logic                 ERR_TIMEOUT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Unpacked views of the packed per-channel buses
    logic [15:0] ch_len  [NUM_CH];
    logic [47:0] ch_mac  [NUM_CH];
    logic [31:0] ch_ip   [NUM_CH];
    logic [15:0] ch_dport[NUM_CH];
    logic [15:0] ch_sport[NUM_CH];
    logic [31:0] ch_data [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign ch_len[gi]   = CH_SEND_LENGTH[16*gi +: 16];
        assign ch_mac[gi]   = CH_SEND_MAC_ADDRESS[48*gi +: 48];
        assign ch_ip[gi]    = CH_SEND_IP_ADDRESS[32*gi +: 32];
        assign ch_dport[gi] = CH_SEND_DST_PORT[16*gi +: 16];
        assign ch_sport[gi] = CH_SEND_SRC_PORT[16*gi +: 16];
        assign ch_data[gi]  = CH_SEND_DATA[32*gi +: 32];
    end

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [CH_W-1:0]     act_q, act_d;
    logic [15:0]         wd_q, wd_d;
    logic [NUM_CH-1:0]   busy_q, busy_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic                req_q, req_d;
    logic                err_len_q, err_len_d;
    logic                err_to_q, err_to_d;
    logic [15:0]         len_q, len_d;
    logic [47:0]         mac_q, mac_d;
    logic [31:0]         ip_q, ip_d;
    logic [15:0]         dport_q, dport_d;
    logic [15:0]         sport_q, sport_d;

    logic                win_found;
    logic [CH_W-1:0]     win_idx;
    logic [CH_W-1:0]     scan_idx;

    // Round-robin search starting just after the last granted channel.
    // Scanning from the farthest candidate down lets the nearest one win.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            scan_idx = CH_W'((int'(ptr_q) + i) % NUM_CH);
            if (CH_SEND_REQUEST[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        act_d     = act_q;
        wd_d      = wd_q;
        busy_d    = busy_q;
        done_d    = '0;
        req_d     = req_q;
        err_len_d = 1'b0;
        err_to_d  = 1'b0;
        len_d     = len_q;
        mac_d     = mac_q;
        ip_d      = ip_q;
        dport_d   = dport_q;
        sport_d   = sport_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    act_d           = win_idx;
                    len_d           = ch_len[win_idx];
                    mac_d           = ch_mac[win_idx];
                    ip_d            = ch_ip[win_idx];
                    dport_d         = ch_dport[win_idx];
                    sport_d         = ch_sport[win_idx];
                    busy_d          = '0;
                    busy_d[win_idx] = 1'b1;
                    if (ch_len[win_idx] == 16'd0) begin
                        // Rejected without ever touching the downstream port
                        state_d         = ST_DONE;
                        done_d[win_idx] = 1'b1;
                        err_len_d       = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        wd_d    = '0;
                    end
                end
            end
            ST_REQ: begin
                if (SEND_BUSY) begin
                    state_d = ST_XFER;
                    req_d   = 1'b0;
                end else if (wd_q == 16'(TIMEOUT - 1)) begin
                    // SEND_REQUEST has now been high for TIMEOUT cycles
                    state_d       = ST_DONE;
                    req_d         = 1'b0;
                    err_to_d      = 1'b1;
                    done_d[act_q] = 1'b1;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            ST_XFER: begin
                if (!SEND_BUSY) begin
                    state_d       = ST_DONE;
                    done_d[act_q] = 1'b1;
                end
            end
            ST_DONE: begin
                ptr_d   = act_q;
                busy_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            ptr_q     <= CH_W'(NUM_CH - 1);
            act_q     <= '0;
            wd_q      <= '0;
            busy_q    <= '0;
            done_q    <= '0;
            req_q     <= 1'b0;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
            len_q     <= '0;
            mac_q     <= '0;
            ip_q      <= '0;
            dport_q   <= '0;
            sport_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            act_q     <= act_d;
            wd_q      <= wd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            req_q     <= req_d;
            err_len_q <= err_len_d;
            err_to_q  <= err_to_d;
            len_q     <= len_d;
            mac_q     <= mac_d;
            ip_q      <= ip_d;
            dport_q   <= dport_d;
            sport_q   <= sport_d;
        end
    end

    // Zero-latency payload path, only open while transferring
    always_comb begin
        CH_SEND_DATA_READ = '0;
        SEND_DATA_VALID   = 1'b0;
        SEND_DATA         = '0;
        if (state_q == ST_XFER) begin
            SEND_DATA_VALID          = CH_SEND_DATA_VALID[act_q];
            SEND_DATA                = ch_data[act_q];
            CH_SEND_DATA_READ[act_q] = SEND_DATA_READ;
        end
    end

    assign CH_SEND_BUSY     = busy_q;
    assign CH_SEND_DONE     = done_q;
    assign SEND_REQUEST     = req_q;
    assign SEND_LENGTH      = len_q;
    assign SEND_MAC_ADDRESS = mac_q;
    assign SEND_IP_ADDRESS  = ip_q;
    assign SEND_DST_PORT    = dport_q;
    assign SEND_SRC_PORT    = sport_q;
    assign ACTIVE_CH        = act_q;
    assign ERR_LENGTH       = err_len_q;
    assign ERR_TIMEOUT      = err_to_q;

endmodule
`default_nettype wire

// File: tb/tb_aq_gemac_udp_send_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_aq_gemac_udp_send_arb
// Purpose  : Directed self-checking bench for aq_gemac_udp_send_arb with a
//            grant-order scoreboard and a simple udp_ctrl responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_aq_gemac_udp_send_arb;

    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int TIMEOUT = 20;

    logic                 CLK;
    logic                 RST_N;
    logic [NUM_CH-1:0]    CH_SEND_REQUEST;
    logic [16*NUM_CH-1:0] CH_SEND_LENGTH;
    logic [48*NUM_CH-1:0] CH_SEND_MAC_ADDRESS;
    logic [32*NUM_CH-1:0] CH_SEND_IP_ADDRESS;
    logic [16*NUM_CH-1:0] CH_SEND_DST_PORT;
    logic [16*NUM_CH-1:0] CH_SEND_SRC_PORT;
    logic [NUM_CH-1:0]    CH_SEND_DATA_VALID;
    logic [32*NUM_CH-1:0] CH_SEND_DATA;
    logic [NUM_CH-1:0]    CH_SEND_DATA_READ;
    logic [NUM_CH-1:0]    CH_SEND_BUSY;
    logic [NUM_CH-1:0]    CH_SEND_DONE;
    logic                 SEND_REQUEST;
    logic [15:0]          SEND_LENGTH;
    logic [47:0]          SEND_MAC_ADDRESS;
    logic [31:0]          SEND_IP_ADDRESS;
    logic [15:0]          SEND_DST_PORT;
    logic [15:0]          SEND_SRC_PORT;
    logic                 SEND_BUSY;
    logic                 SEND_DATA_VALID;
    logic                 SEND_DATA_READ;
    logic [31:0]          SEND_DATA;
    logic [CH_W-1:0]      ACTIVE_CH;
    logic                 ERR_LENGTH;
    logic                 ERR_TIMEOUT;

    aq_gemac_udp_send_arb #(.NUM_CH(NUM_CH), .CH_W(CH_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK                 (CLK),
        .RST_N               (RST_N),
        .CH_SEND_REQUEST     (CH_SEND_REQUEST),
        .CH_SEND_LENGTH      (CH_SEND_LENGTH),
        .CH_SEND_MAC_ADDRESS (CH_SEND_MAC_ADDRESS),
        .CH_SEND_IP_ADDRESS  (CH_SEND_IP_ADDRESS),
        .CH_SEND_DST_PORT    (CH_SEND_DST_PORT),
        .CH_SEND_SRC_PORT    (CH_SEND_SRC_PORT),
        .CH_SEND_DATA_VALID  (CH_SEND_DATA_VALID),
        .CH_SEND_DATA        (CH_SEND_DATA),
        .CH_SEND_DATA_READ   (CH_SEND_DATA_READ),
        .CH_SEND_BUSY        (CH_SEND_BUSY),
        .CH_SEND_DONE        (CH_SEND_DONE),
        .SEND_REQUEST        (SEND_REQUEST),
        .SEND_LENGTH         (SEND_LENGTH),
        .SEND_MAC_ADDRESS    (SEND_MAC_ADDRESS),
        .SEND_IP_ADDRESS     (SEND_IP_ADDRESS),
        .SEND_DST_PORT       (SEND_DST_PORT),
        .SEND_SRC_PORT       (SEND_SRC_PORT),
        .SEND_BUSY           (SEND_BUSY),
        .SEND_DATA_VALID     (SEND_DATA_VALID),
        .SEND_DATA_READ      (SEND_DATA_READ),
        .SEND_DATA           (SEND_DATA),
        .ACTIVE_CH           (ACTIVE_CH),
        .ERR_LENGTH          (ERR_LENGTH),
        .ERR_TIMEOUT         (ERR_TIMEOUT)
    );

    // Client-side stimulus arrays, packed onto the DUT buses below
    logic [NUM_CH-1:0] c_req;
    logic [15:0] c_len  [NUM_CH];
    logic [47:0] c_mac  [NUM_CH];
    logic [31:0] c_ip   [NUM_CH];
    logic [15:0] c_dport[NUM_CH];
    logic [15:0] c_sport[NUM_CH];
    logic [31:0] c_data [NUM_CH];

    always_comb begin
        CH_SEND_REQUEST    = c_req;
        CH_SEND_DATA_VALID = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            CH_SEND_LENGTH[16*i +: 16]      = c_len[i];
            CH_SEND_MAC_ADDRESS[48*i +: 48] = c_mac[i];
            CH_SEND_IP_ADDRESS[32*i +: 32]  = c_ip[i];
            CH_SEND_DST_PORT[16*i +: 16]    = c_dport[i];
            CH_SEND_SRC_PORT[16*i +: 16]    = c_sport[i];
            CH_SEND_DATA[32*i +: 32]        = c_data[i];
        end
    end

    wire [177:0] all_outs = {CH_SEND_DATA_READ, CH_SEND_BUSY, CH_SEND_DONE, SEND_REQUEST,
                             SEND_LENGTH, SEND_MAC_ADDRESS, SEND_IP_ADDRESS, SEND_DST_PORT,
                             SEND_SRC_PORT, SEND_DATA_VALID, SEND_DATA, ACTIVE_CH,
                             ERR_LENGTH, ERR_TIMEOUT};

    int checks   = 0;
    int failures = 0;
    int exp_q[$];          // scoreboard: expected grant order
    int rereq[NUM_CH];     // extra requests a channel issues after its DONE
    bit ds_en;             // downstream responder raises SEND_BUSY when set
    bit hdr_chk;
    logic [47:0] exp_mac;
    logic [15:0] exp_len;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // udp_ctrl stand-in: accepts a request after 3 cycles, consumes ceil(len/4) words
    initial begin
        int ds_cnt;
        int ds_words;
        ds_cnt   = 0;
        ds_words = 0;
        SEND_BUSY      = 1'b0;
        SEND_DATA_READ = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                SEND_BUSY      = 1'b0;
                SEND_DATA_READ = 1'b0;
                ds_cnt         = 0;
                ds_words       = 0;
            end else if (!SEND_BUSY) begin
                SEND_DATA_READ = 1'b0;
                if (SEND_REQUEST && ds_en) begin
                    if (ds_cnt == 2) begin
                        SEND_BUSY = 1'b1;
                        ds_words  = (int'(SEND_LENGTH) + 3) / 4;
                        ds_cnt    = 0;
                    end else begin
                        ds_cnt++;
                    end
                end else begin
                    ds_cnt = 0;
                end
            end else begin
                if (SEND_DATA_READ) ds_words--;
                if (ds_words <= 0) begin
                    SEND_BUSY      = 1'b0;
                    SEND_DATA_READ = 1'b0;
                end else begin
                    SEND_DATA_READ = SEND_DATA_VALID;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs the arbiter until all scoreboard entries are granted and everything is idle.
    task automatic run(input int budget, input int exp_errlen, input int exp_errto);
        int cyc = 0;
        int g = 0;
        int gap = 0;
        int req_hi = 0;
        int grants = 0;
        int dones = 0;
        int n_errlen = 0;
        int n_errto = 0;
        bit seen_done = 0;
        bit finished = 0;
        logic [NUM_CH-1:0] prev_busy = '0;
        while (cyc < budget && !finished) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (CH_SEND_BUSY != '0 && prev_busy == '0) begin
                for (int i = 0; i < NUM_CH; i++) if (CH_SEND_BUSY[i]) g = i;
                grants++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL grant_unexpected observed=ch%0d expected=none", g);
                end
                if (exp_q.size() != 0) chk("grant_order", 64'(g), 64'(exp_q.pop_front()));
                chk("active_ch", 64'(ACTIVE_CH), 64'(g));
                chk("hdr_len", 64'(SEND_LENGTH), 64'(c_len[g]));
                chk("hdr_ip", 64'(SEND_IP_ADDRESS), 64'(c_ip[g]));
                chk("hdr_ports", 64'({SEND_DST_PORT, SEND_SRC_PORT}), 64'({c_dport[g], c_sport[g]}));
                if (seen_done) chk("idle_gap", 64'(gap), 64'd1);
                req_hi = 0;
                if (hdr_chk && g == 1) begin
                    c_mac[1] = 48'hFFFF_FFFF_FFFF;
                    c_len[1] = 16'd4;
                end
                c_req[g] = 1'b0;
            end
            if (SEND_REQUEST) req_hi++;
            chk("busy_onehot0", 64'($onehot0(CH_SEND_BUSY)), 64'd1);
            if (hdr_chk && CH_SEND_BUSY != '0) begin
                chk("latched_mac", 64'(SEND_MAC_ADDRESS), 64'(exp_mac));
                chk("latched_len", 64'(SEND_LENGTH), 64'(exp_len));
            end
            if (SEND_DATA_VALID) begin
                chk("send_data", 64'(SEND_DATA), 64'(c_data[g]));
                chk("read_route", 64'(CH_SEND_DATA_READ),
                    SEND_DATA_READ ? (64'd1 << g) : 64'd0);
            end else begin
                chk("idle_payload_zero", {28'd0, CH_SEND_DATA_READ, SEND_DATA}, 64'd0);
            end
            if (CH_SEND_DONE != '0) begin
                chk("done_ch", 64'(CH_SEND_DONE), 64'd1 << g);
                dones++;
                seen_done = 1;
                gap = 0;
                if (rereq[g] > 0) begin
                    rereq[g]--;
                    c_req[g] = 1'b1;
                end
            end else if (CH_SEND_BUSY == '0) begin
                gap++;
            end
            if (ERR_LENGTH) begin
                n_errlen++;
                chk("errlen_no_request", 64'(req_hi), 64'd0);
                chk("errlen_with_done", 64'(CH_SEND_DONE), 64'd1 << g);
            end
            if (ERR_TIMEOUT) begin
                n_errto++;
                chk("timeout_req_cycles", 64'(req_hi), 64'(TIMEOUT));
                chk("timeout_with_done", 64'(CH_SEND_DONE), 64'd1 << g);
                ds_en = 1'b1;
            end
            prev_busy = CH_SEND_BUSY;
            finished = (exp_q.size() == 0) && (CH_SEND_BUSY == '0) && (c_req == '0);
        end
        checks++;
        assert (finished) else begin
            failures++;
            $error("FAIL run_budget observed=%0d_cycles expected=idle_within_%0d", cyc, budget);
        end
        chk("done_count", 64'(dones), 64'(grants));
        chk("errlen_count", 64'(n_errlen), 64'(exp_errlen));
        chk("errto_count", 64'(n_errto), 64'(exp_errto));
        exp_q.delete();
    endtask

    initial begin
        RST_N   = 1'b0;
        c_req   = '0;
        ds_en   = 1'b1;
        hdr_chk = 1'b0;
        exp_mac = '0;
        exp_len = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rereq[i]   = 0;
            c_len[i]   = 16'd8;
            c_mac[i]   = 48'h0A00_0000_0000 | 48'(i);
            c_ip[i]    = 32'hC0A8_0100 | 32'(i);
            c_dport[i] = 16'd1000 + 16'(i);
            c_sport[i] = 16'd2000 + 16'(i);
            c_data[i]  = 32'hDA7A_0000 | 32'(i);
        end
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs_zero", 64'(|all_outs), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Round-robin from reset: all four request together
        c_req = 4'b1111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        run(400, 0, 0);

        // Fairness: ch0 and ch2 each re-request once after their DONE
        rereq[0] = 1;
        rereq[2] = 1;
        c_req = 4'b0101;
        exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(2);
        run(400, 0, 0);

        // Header latch: ch1 inputs are altered right after its grant
        c_mac[1] = 48'h02_00_00_00_00_01;
        c_len[1] = 16'd16;
        exp_mac  = 48'h02_00_00_00_00_01;
        exp_len  = 16'd16;
        hdr_chk  = 1'b1;
        c_req    = 4'b0010;
        exp_q.push_back(1);
        run(200, 0, 0);
        hdr_chk  = 1'b0;
        c_mac[1] = 48'h0A00_0000_0001;

        // Zero-length request on ch3
        c_len[1] = 16'd8;
        c_len[3] = 16'd0;
        c_req    = 4'b1000;
        exp_q.push_back(3);
        run(50, 1, 0);
        c_len[3] = 16'd8;

        // Watchdog: ch1 never gets SEND_BUSY, then pending ch2 is served
        ds_en = 1'b0;
        c_req = 4'b0110;
        exp_q.push_back(1); exp_q.push_back(2);
        run(200, 0, 1);
        ds_en = 1'b1;

        // Reset in the middle of a transfer
        c_len[3] = 16'd64;
        c_req    = 4'b1000;
        begin
            bit in_xfer = 0;
            for (int i = 0; i < 60 && !in_xfer; i++) begin
                @(posedge CLK);
                #1;
                in_xfer = SEND_DATA_VALID;
            end
            chk("reached_xfer", 64'(in_xfer), 64'd1);
        end
        #2;
        RST_N = 1'b0;
        #1;
        chk("midxfer_reset_outputs_zero", 64'(|all_outs), 64'd0);
        repeat (2) begin
            @(posedge CLK);
            #1;
            chk("reset_no_done", 64'(CH_SEND_DONE), 64'd0);
        end
        c_len[3] = 16'd8;
        c_req    = 4'b1001;
        @(negedge CLK);
        RST_N = 1'b1;
        exp_q.push_back(0); exp_q.push_back(3);
        run(300, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
